// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int FETCH_FIFO_DEPTH = 2;
  localparam int FETCH_AW         = 32;
  localparam int FETCH_DW         = 32;

  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_DW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small flushable FIFO holding fetched {pc, instr} entries; head reads as zero when empty.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   push_i,
  input  logic   pop_i,
  input  logic   flush_i,
  input  entry_t push_data_i,
  output logic   full_o,
  output logic   empty_o,
  output entry_t head_o
);

  localparam int PTR_W = $clog2(FETCH_FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  entry_t             mem_q [FETCH_FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_q, rd_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               do_push, do_pop;

  assign full_o  = (cnt_q == CNT_W'(FETCH_FIFO_DEPTH));
  assign empty_o = (cnt_q == '0);
  assign do_pop  = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push = push_i & (~full_o | do_pop);
  assign head_o  = empty_o ? '0 : mem_q[rd_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < FETCH_FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= wr_q + 1'b1;
      end
      if (do_pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC register driving a combinational ROM, 2-entry output buffer,
// redirect flush. Define INSTR_FETCH_PERF_EN to enable the back-pressure stall counter.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
  parameter logic [ADDRESS_WIDTH-1:0] PC_STEP       = ADDRESS_WIDTH'(1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  output logic [ADDRESS_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0]    rom_dout,
  input  logic                     redirect_valid,
  input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_instr,
  output logic [ADDRESS_WIDTH-1:0] out_pc,
  output logic [31:0]              perf_stall_cnt
);

  typedef struct packed {
    logic [ADDRESS_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0]    instr;
  } entry_t;

  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic   full, empty, pop, push;
  entry_t head, wr_entry;

  assign rom_addr  = pc_q;
  assign out_valid = ~empty;
  assign out_instr = head.instr;
  assign out_pc    = head.pc;
  assign pop       = out_valid & out_ready;
  assign push      = ~redirect_valid & (~full | pop);
  assign wr_entry  = '{pc: pc_q, instr: rom_dout};

  always_comb begin
    pc_d = pc_q;
    if (redirect_valid) pc_d = redirect_pc;
    else if (push)      pc_d = pc_q + PC_STEP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  fetch_fifo #(.entry_t(entry_t)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .push_data_i (wr_entry),
    .full_o      (full),
    .empty_o     (empty),
    .head_o      (head)
  );

`ifdef INSTR_FETCH_PERF_EN
  logic [31:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  stall_q <= '0;
    else if (out_valid && !out_ready && stall_q != '1) stall_q <= stall_q + 32'd1;
  end

  assign perf_stall_cnt = stall_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: streaming, back-pressure, redirect, PC wrap, async reset.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] rom_addr, rom_dout, redirect_pc, out_instr, out_pc, perf_stall_cnt;
  logic        redirect_valid, out_valid, out_ready;

  always #5 clk = ~clk;

  instr_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rom_addr       (rom_addr),
    .rom_dout       (rom_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .perf_stall_cnt (perf_stall_cnt)
  );

`ifdef INSTR_FETCH_PERF_EN
  localparam logic [31:0] PERF_EXP = 32'd4;
`else
  localparam logic [31:0] PERF_EXP = 32'd0;
`endif

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   sb_on = 1'b0;
  int   n;

  function automatic logic [31:0] rom_f(input logic [31:0] a);
    return (a < 32'd4) ? 32'hA0 + a : (32'hC0DE_0000 | {16'h0, a[15:0]});
  endfunction

  assign rom_dout = rom_f(rom_addr);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = rom_f(pc);
    exp_q.push_back(e);
  endtask

  task automatic drain(output int cyc);
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 20) begin
      step();
      cyc++;
    end
    if (exp_q.size() != 0) begin
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
      exp_q.delete();
    end
    sb_on = 1'b0;
  endtask

  // Accepted handshakes are compared in order against the expected stream.
  always @(negedge clk) begin
    if (sb_on && out_valid && out_ready) begin
      if (exp_q.size() == 0) chk("sb_extra", 64'd1, 64'd0);
      else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_pc", 64'(out_pc), 64'(e.pc));
        chk("sb_instr", 64'(out_instr), 64'(e.instr));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; out_ready = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
    step();
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_instr", 64'(out_instr), 64'd0);
    chk("rst_pc",    64'(out_pc), 64'd0);
    chk("rst_addr",  64'(rom_addr), 64'd0);
    chk("rst_perf",  64'(perf_stall_cnt), 64'd0);

    // streaming with out_ready high
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) push_exp(32'(i));
    sb_on = 1'b1;
    step();
    chk("stream_valid_c1", 64'(out_valid), 64'd1);
    drain(n);
    chk("stream_cycles", 64'(n), 64'd4);

    // back-pressure for 5 cycles after reset
    rst_n = 1'b0; out_ready = 1'b0;
    step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("bp_addr",  64'(rom_addr), 64'd2);
    chk("bp_valid", 64'(out_valid), 64'd1);
    chk("bp_head",  64'(out_pc), 64'd0);
    chk("bp_perf",  64'(perf_stall_cnt), 64'(PERF_EXP));
    for (int i = 0; i < 4; i++) push_exp(32'(i));
    sb_on = 1'b1; out_ready = 1'b1;
    drain(n);
    chk("bp_resume_cycles", 64'(n), 64'd4);

    // redirect while full
    out_ready = 1'b0;
    repeat (3) step();
    redirect_valid = 1'b1; redirect_pc = 32'h40;
    step();
    redirect_valid = 1'b0;
    chk("redir_valid0", 64'(out_valid), 64'd0);
    chk("redir_addr",   64'(rom_addr), 64'h40);
    step();
    chk("redir_valid1", 64'(out_valid), 64'd1);
    chk("redir_pc",     64'(out_pc), 64'h40);
    chk("redir_instr",  64'(out_instr), 64'(rom_f(32'h40)));

    // PC wrap at 2^32-1
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFF;
    step();
    redirect_valid = 1'b0;
    chk("wrap_addr", 64'(rom_addr), 64'hFFFF_FFFF);
    push_exp(32'hFFFF_FFFF);
    push_exp(32'h0);
    sb_on = 1'b1; out_ready = 1'b1;
    drain(n);
    chk("wrap_cycles", 64'(n), 64'd3);

    // async reset with FIFO full takes effect before the next edge
    out_ready = 1'b0;
    repeat (3) step();
    chk("full_pre_rst", 64'(out_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_addr",  64'(rom_addr), 64'd0);
    chk("arst_pc",    64'(out_pc), 64'd0);
    chk("arst_instr", 64'(out_instr), 64'd0);
    chk("arst_perf",  64'(perf_stall_cnt), 64'd0);
    step();
    rst_n = 1'b1;
    step();
    chk("post_rst_valid", 64'(out_valid), 64'd1);
    chk("post_rst_pc",    64'(out_pc), 64'd0);

    // redirect coinciding with a pop leaves the FIFO empty
    out_ready = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h10;
    step();
    redirect_valid = 1'b0;
    chk("rpop_valid", 64'(out_valid), 64'd0);
    chk("rpop_pc0",   64'(out_pc), 64'd0);
    chk("rpop_addr",  64'(rom_addr), 64'h10);
    step();
    chk("rpop_pc",    64'(out_pc), 64'h10);
    chk("rpop_instr", 64'(out_instr), 64'(rom_f(32'h10)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The module SHALL have parameter ADDRESS_WIDTH, default 32, PC and instruction-memory address width.
REQ-002 The module SHALL have parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 The module SHALL have parameter RESET_PC, default 0, PC value loaded at reset.
REQ-004 The module SHALL have parameter PC_STEP, default 1, PC increment per fetch, in memory-word units.
REQ-005 The module SHALL use one clock; reset is asynchronous and active-low.
REQ-006 Ports SHALL be:
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- rom_addr  out  ADDRESS_WIDTH  address to the combinational instruction ROM.
- rom_dout  in  DATA_WIDTH  ROM read data, valid in the same cycle as rom_addr.
- redirect_valid  in  1  branch/jump redirect request.
- redirect_pc  in  ADDRESS_WIDTH  redirect target.
- out_valid  out  1  instruction available to decode.
- out_ready  in  1  decode accepts the instruction.
- out_instr  out  DATA_WIDTH  instruction word.
- out_pc  out  ADDRESS_WIDTH  PC of out_instr.
- perf_stall_cnt  out  32  back-pressure cycle count.

Function
REQ-007 rom_addr SHALL equal the internal PC register combinationally.
REQ-008 A 2-entry FIFO of {pc, instr} entries SHALL buffer fetched words; out_valid SHALL equal FIFO not-empty; out_instr and out_pc SHALL show the head entry.
REQ-009 Pop SHALL occur when out_valid && out_ready.
REQ-010 Push SHALL occur when !redirect_valid and (FIFO not full or pop in the same cycle); the pushed entry SHALL be {PC, rom_dout}, and the PC SHALL advance to PC+PC_STEP, modulo 2^ADDRESS_WIDTH.
REQ-011 When no push occurs and redirect_valid is low, the PC SHALL hold.
REQ-012 When redirect_valid is high, the FIFO SHALL flush to empty at the clock edge, the PC SHALL load redirect_pc, and no push SHALL occur; this overrides any simultaneous pop or push.
REQ-013 The first instruction from redirect_pc SHALL appear on out_valid one cycle after the redirect edge.
REQ-014 Latency SHALL be 1 cycle from the edge at which rom_addr is presented to out_valid for that entry when the FIFO is empty.
REQ-015 With out_ready held high and no redirect, throughput SHALL be one instruction per cycle with no bubbles.
REQ-016 Full FIFO with a pop in the same cycle SHALL pop and push in that cycle; occupancy SHALL stay 2.
REQ-017 out_instr and out_pc SHALL be 0 when the FIFO is empty.

Reset
REQ-018 Asserting rst_n low SHALL immediately set PC=RESET_PC, empty the FIFO, and drive out_valid=0, out_instr=0, out_pc=0, perf_stall_cnt=0.
REQ-019 Reset asserted mid-operation SHALL discard all buffered entries.
REQ-020 The first push after deassertion SHALL occur at the first rising edge with rst_n high.

Configuration
REQ-021 Macro INSTR_FETCH_PERF_EN SHALL control the performance counter.
REQ-022 When INSTR_FETCH_PERF_EN is defined, perf_stall_cnt SHALL increment by 1 on each cycle with out_valid && !out_ready, saturating at 2^32-1.
REQ-023 When INSTR_FETCH_PERF_EN is undefined, perf_stall_cnt SHALL be constant 0 and no counter logic SHALL be present.

Structure
REQ-024 Package fetch_pkg SHALL hold the fetch_entry_t typedef {pc, instr} and the constant FETCH_FIFO_DEPTH=2.
REQ-025 The FIFO SHALL be sub-module fetch_fifo with push, pop, flush, full, empty and head ports; instr_fetch SHALL hold the PC, control and counter logic.

Verification
REQ-026 The bench SHALL cover: reset release with RESET_PC=0, ROM[0..3]=0xA0..0xA3, out_ready=1 -> out_valid high from cycle 1; (pc, instr) sequence (0,0xA0),(1,0xA1),(2,0xA2),(3,0xA3) on consecutive cycles.
REQ-027 The bench SHALL cover: out_ready=0 for 5 cycles after reset -> FIFO holds pc 0 and 1; rom_addr stays at 2; perf_stall_cnt=4 with the macro defined and 0 without it; on out_ready=1 the sequence resumes at pc 0 with no loss.
REQ-028 The bench SHALL cover: redirect_valid for 1 cycle with redirect_pc=0x40 while the FIFO is full -> out_valid=0 on the next cycle; the cycle after that shows out_pc=0x40 with the instruction from ROM[0x40].
REQ-029 The bench SHALL cover: PC=2^ADDRESS_WIDTH-1 with PC_STEP=1 -> next fetch address 0; out_pc sequence 0xFFFFFFFF, 0x0.
REQ-030 The bench SHALL cover: rst_n pulsed low mid-stream with the FIFO at occupancy 2 -> out_valid=0 and rom_addr=RESET_PC immediately, before the next clock edge.
REQ-031 The bench SHALL cover: a redirect coinciding with out_valid && out_ready -> the head is considered consumed, nothing is pushed, and the FIFO is empty after the edge.
